barrel_shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit logical barrel shifter between several requesters. Each requester presents a word, shift amount and direction with a valid/ready handshake. The block grants one requester per cycle, performs the shift, and holds the result in a single-entry output register until the consumer accepts it. It sits between the requesting datapath units and the downstream consumer.

---
 rtl/barrel_shift_arbiter.sv | 160 ++++++++++++++++
 tb/tb_barrel_shift_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter
// Round-robin arbiter that shares one barrel shifter between NUM_REQ
// requesters and holds each result in a single-entry output slot until the
// consumer accepts it.
//
// Optional build macro: BARREL_SHIFT_ARB_ROTATE_EN
//   defined   -> datapath rotates (left: MSB wraps into LSB; right: LSB wraps into MSB)
//   undefined -> logical zero-fill shift
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]          per-requester request valid
//   req_ready  out  [NUM_REQ]          per-requester accept (combinational)
//   req_data   in   [NUM_REQ*DATA_W]   requester i word at [i*DATA_W +: DATA_W]
//   req_shift  in   [NUM_REQ*SHIFT_W]  requester i amount at [i*SHIFT_W +: SHIFT_W]
//   req_dire   in   [NUM_REQ]          0 = left, 1 = right
//   out_valid  out  result slot holds a result
//   out_ready  in   consumer accepts the result
//   out_data   out  [DATA_W]           shifted result
//   out_id     out  [clog2(NUM_REQ)]   requester index that produced out_data
module barrel_shift_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned SHIFT_W = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ*SHIFT_W-1:0]   req_shift,
    input  logic [NUM_REQ-1:0]           req_dire,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(NUM_REQ)-1:0]   out_id
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [DATA_W-1:0]   r_out_data;
    logic [ID_W-1:0]     r_out_id;

    logic                w_slot_free;
    logic                w_found;
    logic [ID_W-1:0]     w_gnt_idx;
    logic [ID_W-1:0]     w_cand;
    int unsigned         w_idx;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_sel_data;
    logic [SHIFT_W-1:0]  w_sel_shift;
    logic                w_sel_dire;
    logic [DATA_W-1:0]   w_left;
    logic [DATA_W-1:0]   w_right;
    logic [DATA_W-1:0]   w_shifted;

    // Slot can take a new result when empty or when it drains this cycle.
    assign w_slot_free = (r_state == S_EMPTY) | out_ready;

    // Round-robin search: first valid requester at or after r_ptr, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        w_idx     = 0;
        w_grant   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_cand = ID_W'(w_idx);
            if (!w_found && req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        w_grant[w_gnt_idx] = w_found;
    end

    // Ready is forced low while reset is asserted, not just after it.
    assign w_xfer    = w_found & w_slot_free & rst_n;
    assign req_ready = w_grant & {NUM_REQ{w_slot_free & rst_n}};

    // Mux out the granted requester's operands.
    always_comb begin
        w_sel_data  = req_data[32'(w_gnt_idx) * DATA_W +: DATA_W];
        w_sel_shift = req_shift[32'(w_gnt_idx) * SHIFT_W +: SHIFT_W];
        w_sel_dire  = req_dire[w_gnt_idx];
    end

    // Shifter; rotate build ORs in the bits that fall off the far end.
    always_comb begin
        w_left  = w_sel_data << w_sel_shift;
        w_right = w_sel_data >> w_sel_shift;
`ifdef BARREL_SHIFT_ARB_ROTATE_EN
        // A zero shift yields a full-width shift of the wrap term, i.e. zero.
        w_left  = w_left  | (w_sel_data >> (DATA_W - 32'(w_sel_shift)));
        w_right = w_right | (w_sel_data << (DATA_W - 32'(w_sel_shift)));
`endif
        w_shifted = w_sel_dire ? w_right : w_left;
    end

    // Output slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot next state: fill on transfer, drain on consumer accept.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_xfer) begin
                    w_state_nxt = S_FULL;
                end else if (out_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Result payload and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_id   <= '0;
            r_ptr      <= '0;
        end else if (w_xfer) begin
            r_out_data <= w_shifted;
            r_out_id   <= w_gnt_idx;
            r_ptr      <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter: behavioural slot/round-robin
// model compared every cycle, directed scenarios with literal expectations,
// then randomized traffic with backpressure and occasional resets.
module tb_barrel_shift_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int SW = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*DW-1:0]  req_data;
    logic [N*SW-1:0]  req_shift;
    logic [N-1:0]     req_dire;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_id;

    barrel_shift_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SHIFT_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shift (req_shift),
        .req_dire  (req_dire),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    // Model state: slot contents and round-robin pointer.
    int m_valid, m_data, m_id, m_ptr;
    int last_gnt;

    function automatic int mshift(int d, int s, int dir);
        int r;
`ifdef BARREL_SHIFT_ARB_ROTATE_EN
        if (dir == 0) r = ((d * (1 << s)) % (1 << DW)) + d / (1 << (DW - s));
        else          r = d / (1 << s) + (d % (1 << s)) * (1 << (DW - s));
`else
        if (dir == 0) r = (d * (1 << s)) % (1 << DW);
        else          r = d / (1 << s);
`endif
        return r;
    endfunction

    function automatic int mgrant(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(int i, bit v, int d, int s, bit dir);
        req_valid[i]          = v;
        req_data[i*DW +: DW]  = d[DW-1:0];
        req_shift[i*SW +: SW] = s[SW-1:0];
        req_dire[i]           = dir;
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; last_gnt = -1;
    endtask

    // One clock: compare DUT against the model, then advance the model.
    task automatic cycle();
        int g, free, expr;
        #1;
        g    = mgrant(req_valid, m_ptr);
        free = (m_valid == 0 || out_ready) ? 1 : 0;
        expr = (free != 0 && g >= 0) ? (1 << g) : 0;
        chk("req_ready", int'(req_ready), expr);
        chk("out_valid", int'(out_valid), m_valid);
        if (m_valid != 0) begin
            chk("out_data", int'(out_data), m_data);
            chk("out_id", int'(out_id), m_id);
        end
        @(posedge clk);
        if (free != 0 && g >= 0) begin
            m_data   = mshift(int'(req_data[g*DW +: DW]), int'(req_shift[g*SW +: SW]), int'(req_dire[g]));
            m_id     = g;
            m_valid  = 1;
            m_ptr    = (g + 1) % N;
            last_gnt = g;
        end else begin
            last_gnt = -1;
            if (out_ready) m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_id", int'(out_id), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    int exp_a, exp_b, exp_c, exp_d, exp_e;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        req_shift = '0;
        req_dire  = '0;
        out_ready = 1'b1;
        model_reset();
`ifdef BARREL_SHIFT_ARB_ROTATE_EN
        exp_a = 4'b0111; exp_b = 4'b1101; exp_c = 4'b1101; exp_d = 4'b0110; exp_e = 4'b1001;
`else
        exp_a = 4'b0110; exp_b = 4'b1000; exp_c = 4'b0101; exp_d = 4'b0010; exp_e = 4'b0001;
`endif

        // Power-on reset with all requests valid: nothing may be granted.
        #1;
        chk("por_out_valid", int'(out_valid), 0);
        chk("por_req_ready", int'(req_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;

        // Reset mid-result.
        out_ready = 1'b0;
        set_req(0, 1'b1, 4'b1011, 1, 1'b0);
        cycle();
        req_valid = 4'b0011;
        chk("mid_data_pre", int'(out_data), exp_a);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", int'(out_valid), 0);
        chk("mid_out_data", int'(out_data), 0);
        chk("mid_out_id", int'(out_id), 0);
        chk("mid_req_ready", int'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        out_ready = 1'b1;
        set_req(0, 1'b1, 4'b0001, 0, 1'b0);
        set_req(1, 1'b1, 4'b0010, 0, 1'b0);
        cycle();
        chk("ptr_after_reset", int'(out_id), 0);
        req_valid[0] = 1'b0;
        cycle();
        chk("ptr_after_reset_2", int'(out_id), 1);
        req_valid = '0;
        cycle();

        // Basic shift, left then right.
        set_req(1, 1'b1, 4'b1011, 3, 1'b0);
        cycle();
        req_valid = '0;
        chk("basic_left_data", int'(out_data), exp_b);
        chk("basic_left_id", int'(out_id), 1);
        set_req(1, 1'b1, 4'b1011, 1, 1'b1);
        cycle();
        req_valid = '0;
        chk("basic_right_data", int'(out_data), exp_c);

        // Round-robin with everybody valid.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, i + 1, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_id", int'(out_id), k % N);
        end
        req_valid = '0;
        cycle();

        // Backpressure: first result held, pending request waits.
        out_ready = 1'b0;
        set_req(2, 1'b1, 4'b1001, 2, 1'b1);
        cycle();
        set_req(2, 1'b1, 4'b0011, 1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold_id", int'(out_id), 2);
            chk("bp_hold_data", int'(out_data), exp_d);
        end
        out_ready = 1'b1;
        cycle();
        req_valid = '0;
        chk("bp_release_valid", int'(out_valid), 1);
        chk("bp_release_data", int'(out_data), exp_e);
        cycle();

        // Pointer skip: ptr=1 with only req3 and req0 valid.
        do_reset();
        set_req(0, 1'b1, 4'b0001, 0, 1'b0);
        cycle();
        set_req(3, 1'b1, 4'b0100, 0, 1'b0);
        cycle();
        chk("skip_1", int'(out_id), 3);
        cycle();
        chk("skip_2", int'(out_id), 0);
        cycle();
        chk("skip_3", int'(out_id), 3);
        req_valid = '0;
        cycle();

        // Shift zero, then idle drain.
        set_req(0, 1'b1, 4'b0110, 0, 1'b0);
        cycle();
        req_valid = '0;
        chk("zero_shift_data", int'(out_data), 4'b0110);
        cycle();
        chk("idle_drain", int'(out_valid), 0);

        // Randomized traffic; requests stay stable until accepted.
        for (int c = 0; c < 800; c++) begin
            out_ready = ($urandom % 10) < 7;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 2) == 1)
                    set_req(i, 1'b1, int'($urandom % 16), int'($urandom % 4), 1'($urandom % 2));
            end
            cycle();
            if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
            if (c % 200 == 199) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
